// File: rtl/victim_cache_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lc3b_types (package)
//  Brief    : Shared types for the victim cache: controller state encoding
//             and default line/tag typedefs.
//  Revision : 1.0 - initial release
// ============================================================================
package lc3b_types;

  localparam int unsigned c_line_width = 128;
  localparam int unsigned c_tag_width  = 12;

  typedef logic [c_line_width-1:0] line_t;
  typedef logic [c_tag_width-1:0]  tag_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HIT_RESP = 3'd1,
    S_FILL     = 3'd2,
    S_EVICT_WB = 3'd3,
    S_INSERT   = 3'd4
  } victim_state_e;

endpackage
`default_nettype wire

// File: rtl/victim_cache_param_lru.sv
`default_nettype none
// ============================================================================
//  Module   : victim_lru
//  Brief    : True-LRU age tracker. Ages form a permutation of 0..N-1; the
//             entry whose age is N-1 is the least recently used.
//  Revision : 1.0 - initial release
// ============================================================================
module victim_lru #(
  parameter int NUM_ENTRIES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           touch,
  input  logic [$clog2(NUM_ENTRIES)-1:0] touch_idx,
  output logic [$clog2(NUM_ENTRIES)-1:0] lru_idx
);

  localparam int c_idx_w = $clog2(NUM_ENTRIES);

  logic [c_idx_w-1:0] r_age [NUM_ENTRIES];

  // Age update: touched entry becomes youngest, younger-than-it entries age by one
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_age[i] <= c_idx_w'(i);
    end else if (touch) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (c_idx_w'(i) == touch_idx)         r_age[i] <= '0;
        else if (r_age[i] < r_age[touch_idx]) r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end

  // Oldest entry is the one holding the maximum age
  always_comb begin
    lru_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (r_age[i] == c_idx_w'(NUM_ENTRIES - 1)) lru_idx = c_idx_w'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/victim_cache_param.sv
`default_nettype none
// ============================================================================
//  Module   : victim_cache_param
//  Brief    : Fully associative victim cache between L2 and physical memory.
//             Inserts L2 evictions, serves L2 misses with exclusive hand-back,
//             writes back dirty LRU victims.
//  Options  : VICTIM_PERF_CNT_EN adds saturating hit/miss/writeback counters.
//  Revision : 1.0 - initial release
// ============================================================================
module victim_cache_param
  import lc3b_types::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int TAG_WIDTH   = 12,
  parameter int LINE_WIDTH  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_dirty,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [LINE_WIDTH-1:0] mem_wdata,
  output logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
`ifdef VICTIM_PERF_CNT_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count
`endif
);

  localparam int c_idx_w = $clog2(NUM_ENTRIES);
  localparam int c_off_w = ADDR_WIDTH - TAG_WIDTH;

  victim_state_e         r_state, w_next;
  logic [NUM_ENTRIES-1:0] r_valid, r_dirty;
  logic [TAG_WIDTH-1:0]  r_tag  [NUM_ENTRIES];
  logic [LINE_WIDTH-1:0] r_data [NUM_ENTRIES];
  logic [c_idx_w-1:0]    r_idx;
  logic                  r_new_dirty;

  logic [TAG_WIDTH-1:0]  w_req_tag;
  logic                  w_hit, w_free;
  logic [c_idx_w-1:0]    w_hit_idx, w_free_idx, w_lru_idx, w_sel_idx;
  logic                  w_sel_dirty;

  assign w_req_tag = mem_address[ADDR_WIDTH-1 -: TAG_WIDTH];

  // Tag match and lowest free entry search
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (r_valid[i] && (r_tag[i] == w_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_idx = c_idx_w'(i);
      end
    end
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = c_idx_w'(i);
      end
    end
  end

  // Target entry and merged dirty bit chosen at request time
  always_comb begin
    w_sel_idx   = w_hit ? w_hit_idx : (w_free ? w_free_idx : w_lru_idx);
    w_sel_dirty = w_hit ? (r_dirty[w_hit_idx] | mem_dirty) : mem_dirty;
  end

  victim_lru #(.NUM_ENTRIES(NUM_ENTRIES)) u_lru (
    .clk       (clk),
    .rst       (rst),
    .touch     (r_state == S_INSERT),
    .touch_idx (r_idx),
    .lru_idx   (w_lru_idx)
  );

  // State register plus the entry index latched when a request is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_new_dirty <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_idx       <= w_sel_idx;
        r_new_dirty <= w_sel_dirty;
      end
    end
  end

  // Next-state decision
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_read)                    w_next = w_hit ? S_HIT_RESP : S_FILL;
        else if (mem_write) begin
          if (w_hit || w_free)           w_next = S_INSERT;
          else if (r_dirty[w_lru_idx])   w_next = S_EVICT_WB;
          else                           w_next = S_INSERT;
        end
      end
      S_HIT_RESP: w_next = S_IDLE;
      S_FILL:     if (pmem_resp) w_next = S_IDLE;
      S_EVICT_WB: if (pmem_resp) w_next = S_INSERT;
      S_INSERT:   w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    mem_rdata    = '0;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (r_state)
      S_HIT_RESP: begin
        mem_rdata = r_data[r_idx];
        mem_resp  = 1'b1;
      end
      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = mem_address;
        if (pmem_resp) begin
          mem_rdata = pmem_rdata;
          mem_resp  = 1'b1;
        end
      end
      S_EVICT_WB: begin
        pmem_write   = 1'b1;
        pmem_address = {r_tag[r_idx], {c_off_w{1'b0}}};
        pmem_wdata   = r_data[r_idx];
      end
      S_INSERT: mem_resp = 1'b1;
      default: ;
    endcase
  end

  // Valid/dirty bookkeeping: hand-back invalidates, insert validates
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (r_state == S_HIT_RESP) begin
      r_valid[r_idx] <= 1'b0;
    end else if (r_state == S_INSERT) begin
      r_valid[r_idx] <= 1'b1;
      r_dirty[r_idx] <= r_new_dirty;
    end
  end

  // Tag and line storage, written only on insert
  always_ff @(posedge clk) begin
    if (r_state == S_INSERT) begin
      r_tag[r_idx]  <= w_req_tag;
      r_data[r_idx] <= mem_wdata;
    end
  end

`ifdef VICTIM_PERF_CNT_EN
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (r_state == S_IDLE && w_next == S_HIT_RESP && hit_count != '1)
        hit_count <= hit_count + 32'd1;
      if (r_state == S_IDLE && w_next == S_FILL && miss_count != '1)
        miss_count <= miss_count + 32'd1;
      if (r_state == S_EVICT_WB && pmem_resp && wb_count != '1)
        wb_count <= wb_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_victim_cache_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_victim_cache_param
//  Brief    : Directed table-driven bench for victim_cache_param, plus a
//             hand-written reset-during-writeback sequence.
//  Options  : VICTIM_PERF_CNT_EN enables counter checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_victim_cache_param;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write, mem_dirty;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_resp, pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
`ifdef VICTIM_PERF_CNT_EN
  logic [31:0]  hit_count, miss_count, wb_count;
  int           e_hit, e_miss, e_wb;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] c_pd = {8{16'hF00D}};

  victim_cache_param #(
    .NUM_ENTRIES(16), .ADDR_WIDTH(16), .TAG_WIDTH(12), .LINE_WIDTH(128)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_dirty(mem_dirty),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef VICTIM_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           do_rst;
    bit           is_wr;
    logic [15:0]  addr;
    bit           dirty;
    logic [127:0] wdata;
    logic [127:0] pdata;
    int           exp_lat;
    logic [127:0] exp_rdata;
    int           exp_pop;     // 0 none, 1 pmem read, 2 pmem write
    logic [15:0]  exp_paddr;
    logic [127:0] exp_pwdata;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [127:0] dline(input logic [11:0] t);
    return {8{4'hD, t}};
  endfunction

  function automatic logic [127:0] eline(input logic [11:0] t);
    return {8{4'hE, t}};
  endfunction

  function automatic vec_t wr(input bit r, input logic [15:0] a, input bit d,
                              input logic [127:0] wd, input int lat, input int pop,
                              input logic [15:0] pa, input logic [127:0] pw);
    vec_t v;
    v.do_rst = r; v.is_wr = 1'b1; v.addr = a; v.dirty = d; v.wdata = wd;
    v.pdata = '0; v.exp_lat = lat; v.exp_rdata = '0; v.exp_pop = pop;
    v.exp_paddr = pa; v.exp_pwdata = pw;
    return v;
  endfunction

  function automatic vec_t rd(input logic [15:0] a, input int lat,
                              input logic [127:0] exp_d, input int pop,
                              input logic [15:0] pa);
    vec_t v;
    v.do_rst = 1'b0; v.is_wr = 1'b0; v.addr = a; v.dirty = 1'b0; v.wdata = '0;
    v.pdata = c_pd; v.exp_lat = lat; v.exp_rdata = exp_d; v.exp_pop = pop;
    v.exp_paddr = pa; v.exp_pwdata = '0;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
`ifdef VICTIM_PERF_CNT_EN
    e_hit = 0; e_miss = 0; e_wb = 0;
`endif
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0, pcyc = 0, pop = 0;
    bit done = 1'b0, both = 1'b0;
    logic [15:0]  paddr = '0;
    logic [127:0] pwd = '0, rdat = '0;
    if (v.do_rst) do_reset();
    mem_address = v.addr; mem_wdata = v.wdata; mem_dirty = v.dirty;
    mem_write = v.is_wr; mem_read = !v.is_wr;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      pmem_resp = 1'b0;
      if (pmem_read || pmem_write) begin
        if (pmem_read && pmem_write) both = 1'b1;
        pop = pmem_read ? 1 : 2;
        paddr = pmem_address; pwd = pmem_wdata;
        pcyc++;
        if (pcyc >= 2) begin
          pmem_rdata = v.pdata; pmem_resp = 1'b1;
          #1;
        end
      end
      if (mem_resp) begin done = 1'b1; rdat = mem_rdata; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL v%0d_timeout actual=no_resp required=resp", idx);
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    check($sformatf("v%0d_latency", idx), 128'(cyc), 128'(v.exp_lat));
    check($sformatf("v%0d_pmem_op", idx), 128'(pop), 128'(v.exp_pop));
    check($sformatf("v%0d_pmem_both", idx), 128'(both), 128'(0));
    if (v.exp_pop != 0) check($sformatf("v%0d_pmem_addr", idx), 128'(paddr), 128'(v.exp_paddr));
    if (v.exp_pop == 2) check($sformatf("v%0d_pmem_wdata", idx), pwd, v.exp_pwdata);
    if (!v.is_wr)       check($sformatf("v%0d_rdata", idx), rdat, v.exp_rdata);
`ifdef VICTIM_PERF_CNT_EN
    if (!v.is_wr && v.exp_pop == 0) e_hit++;
    if (v.exp_pop == 1) e_miss++;
    if (v.exp_pop == 2) e_wb++;
    check($sformatf("v%0d_hit_count", idx), 128'(hit_count), 128'(e_hit));
    check($sformatf("v%0d_miss_count", idx), 128'(miss_count), 128'(e_miss));
    check($sformatf("v%0d_wb_count", idx), 128'(wb_count), 128'(e_wb));
`endif
  endtask

  initial begin
    int wcyc;
    bit seen_wb;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_dirty = 1'b0;
    mem_address = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;

    // Scenario A: insert, exclusive read hit, read miss, fill, dirty LRU writeback
    vecs.push_back(wr(1'b1, 16'h1230, 1'b0, dline(12'h123), 1, 0, '0, '0));
    vecs.push_back(rd(16'h1234, 1, dline(12'h123), 0, '0));
    vecs.push_back(rd(16'h1230, 2, c_pd, 1, 16'h1230));
    for (int t = 0; t < 16; t++)
      vecs.push_back(wr(1'b0, {12'(t), 4'h0}, 1'b1, dline(12'(t)), 1, 0, '0, '0));
    vecs.push_back(wr(1'b0, 16'h1000, 1'b0, dline(12'h100), 3, 2, 16'h0000, dline(12'h000)));
    vecs.push_back(rd(16'h1008, 1, dline(12'h100), 0, '0));
    // Scenario B: rewrite of tag 0 refreshes it, so tag 1 becomes the victim
    for (int t = 0; t < 16; t++)
      vecs.push_back(wr(t == 0, {12'(t), 4'h0}, 1'b1, dline(12'(t)), 1, 0, '0, '0));
    vecs.push_back(wr(1'b0, 16'h0000, 1'b0, eline(12'h000), 1, 0, '0, '0));
    vecs.push_back(wr(1'b0, 16'h1000, 1'b0, dline(12'h100), 3, 2, 16'h0010, dline(12'h001)));
    vecs.push_back(rd(16'h0000, 1, eline(12'h000), 0, '0));
    vecs.push_back(rd(16'h1000, 1, dline(12'h100), 0, '0));
    vecs.push_back(wr(1'b0, 16'h2000, 1'b0, dline(12'h200), 1, 0, '0, '0));
    vecs.push_back(wr(1'b0, 16'h3000, 1'b0, dline(12'h300), 1, 0, '0, '0));
    vecs.push_back(wr(1'b0, 16'h4000, 1'b0, dline(12'h400), 3, 2, 16'h0020, dline(12'h002)));
    vecs.push_back(wr(1'b0, 16'h5000, 1'b0, dline(12'h500), 3, 2, 16'h0030, dline(12'h003)));
    vecs.push_back(rd(16'h4000, 1, dline(12'h400), 0, '0));

    // Reset state
    do_reset();
    check("rst_mem_resp", 128'(mem_resp), 128'(0));
    check("rst_pmem_read", 128'(pmem_read), 128'(0));
    check("rst_pmem_write", 128'(pmem_write), 128'(0));
    check("rst_mem_rdata", mem_rdata, 128'(0));
    check("rst_pmem_address", 128'(pmem_address), 128'(0));
    check("rst_pmem_wdata", pmem_wdata, 128'(0));
`ifdef VICTIM_PERF_CNT_EN
    check("rst_counters", 128'(hit_count | miss_count | wb_count), 128'(0));
`endif

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset while a writeback is pending with pmem_resp withheld
    for (int t = 0; t < 16; t++)
      run_vec(wr(t == 0, {12'(t), 4'h0}, 1'b1, dline(12'(t)), 1, 0, '0, '0), 100 + t);
    mem_address = 16'h1000; mem_wdata = dline(12'h100); mem_dirty = 1'b0; mem_write = 1'b1;
    seen_wb = 1'b0; wcyc = 0;
    while (!seen_wb && wcyc < 10) begin
      @(posedge clk); #1;
      wcyc++;
      if (pmem_write) seen_wb = 1'b1;
    end
    check("rstwb_pmem_write_seen", 128'(seen_wb), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstwb_pmem_write_low", 128'(pmem_write), 128'(0));
    check("rstwb_pmem_read_low", 128'(pmem_read), 128'(0));
    check("rstwb_no_mem_resp", 128'(mem_resp), 128'(0));
    rst = 1'b0; mem_write = 1'b0;
`ifdef VICTIM_PERF_CNT_EN
    e_hit = 0; e_miss = 0; e_wb = 0;
`endif
    for (int t = 0; t < 16; t++)
      run_vec(rd({12'(t), 4'h0}, 2, c_pd, 1, {12'(t), 4'h0}), 200 + t);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
